// File: rtl/noc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : noc_pkg                                                 |
// | Description : Shared types and default widths for the local network  |
// |               interface between a processing core and its router.    |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
package noc_pkg;

   // Default packet/flit width and FIFO pointer width (depth = 2**width).
   localparam int c_DATA_WIDTH    = 32;
   localparam int c_ADDRESS_WIDTH = 2;

   // Injection FSM: IDLE waits for a queued packet, REQ holds the request
   // towards the router local input port until granted or back-pressured.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } txState_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/local_net_iface_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Interface   : local_net_iface_if                                      |
// | Description : Bundles the core-side TX/RX handshakes, the router-side |
// |               request/grant links and the delivery counters.         |
// |               slave  = view of the interface block itself            |
// |               master = view of the environment (core + router)       |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
interface local_net_iface_if #(
   parameter int dataWidth = noc_pkg::c_DATA_WIDTH
);

   // Core -> router injection path
   logic                 txValid;
   logic [dataWidth-1:0] txPacket;
   logic                 txReady;
   logic                 reqDnStr;
   logic                 gntDnStr;
   logic                 dnStrFull;
   logic [dataWidth-1:0] packetOut;

   // Router -> core ejection path
   logic                 reqUpStr;
   logic                 gntUpStr;
   logic                 upStrFull;
   logic [dataWidth-1:0] packetIn;
   logic                 rxValid;
   logic                 rxReady;
   logic [dataWidth-1:0] rxPacket;

   // Delivery statistics
   logic [15:0]          txCount;
   logic [15:0]          rxCount;

   modport slave (
      input  txValid, txPacket, gntDnStr, dnStrFull,
      input  reqUpStr, packetIn, rxReady,
      output txReady, reqDnStr, packetOut,
      output gntUpStr, upStrFull, rxValid, rxPacket,
      output txCount, rxCount
   );

   modport master (
      output txValid, txPacket, gntDnStr, dnStrFull,
      output reqUpStr, packetIn, rxReady,
      input  txReady, reqDnStr, packetOut,
      input  gntUpStr, upStrFull, rxValid, rxPacket,
      input  txCount, rxCount
   );

endinterface : local_net_iface_if
`default_nettype wire

// File: rtl/local_net_iface_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : sync_fifo                                               |
// | Description : Single-clock FIFO of depth 2**addressWidth. Pointers    |
// |               wrap modulo depth; an occupancy counter one bit wider   |
// |               than the pointers separates full from empty. A push    |
// |               into a full FIFO is accepted only together with a pop.  |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module sync_fifo #(
   parameter int dataWidth    = noc_pkg::c_DATA_WIDTH,
   parameter int addressWidth = noc_pkg::c_ADDRESS_WIDTH
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 push,
   input  wire logic                 pop,
   input  wire logic [dataWidth-1:0] din,
   output logic      [dataWidth-1:0] dout,
   output logic                      full,
   output logic                      empty
);

   localparam int                  c_DEPTH = 2**addressWidth;
   localparam logic [addressWidth:0] c_FULL = (addressWidth+1)'(c_DEPTH);

   logic [dataWidth-1:0]    r_mem [c_DEPTH];
   logic [addressWidth-1:0] r_wrPtr;
   logic [addressWidth-1:0] r_rdPtr;
   logic [addressWidth:0]   r_count;

   logic w_doPush;
   logic w_doPop;

   assign full  = (r_count == c_FULL);
   assign empty = (r_count == '0);
   assign dout  = r_mem[r_rdPtr];

   // Pop only real data; a push into a full FIFO needs the slot freed by
   // a pop on the same edge.
   assign w_doPop  = pop && !empty;
   assign w_doPush = push && (!full || w_doPop);

   // Storage array: no reset, contents are qualified by the occupancy.
   always_ff @(posedge clk) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + addressWidth'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + addressWidth'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + (addressWidth+1)'(1);
            2'b01:   r_count <= r_count - (addressWidth+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/local_net_iface.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : local_net_iface                                         |
// | Description : Network interface between a core and the local port of  |
// |               its router. TX packets are buffered and injected with a |
// |               request/grant handshake; RX packets are pulled from the |
// |               router with single-cycle grants and buffered for the    |
// |               core. Delivery counters wrap at 16 bits.                |
// | Revision    : 1.0  initial release                                    |
// +-----------------------------------------------------------------------+
module local_net_iface
   import noc_pkg::*;
#(
   parameter int dataWidth    = c_DATA_WIDTH,
   parameter int addressWidth = c_ADDRESS_WIDTH,
   parameter int routerNo     = 0
) (
   input wire logic          clk,
   input wire logic          rst,
   local_net_iface_if.slave  bus
);

   // routerNo only labels the instance; it has no effect on the logic.
   if (routerNo < 0) begin : g_routerNoCheck
   end

   // ------------------------------------------------------------------
   // TX path: core -> TX FIFO -> router local input port
   // ------------------------------------------------------------------
   txState_t             r_state;
   logic                 r_reqDnStr;
   logic [dataWidth-1:0] r_packetOut;
   logic [15:0]          r_txCount;

   logic                 w_txFull;
   logic                 w_txEmpty;
   logic                 w_txPush;
   logic                 w_txPop;
   logic [dataWidth-1:0] w_txHead;

   // Ready reflects the occupancy before any pop of this cycle, so a
   // full FIFO never takes a packet even if the router grants now.
   assign w_txPush = bus.txValid && !w_txFull;
   assign w_txPop  = (r_state == REQ) && bus.gntDnStr;

   sync_fifo #(
      .dataWidth    (dataWidth),
      .addressWidth (addressWidth)
   ) u_txFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_txPush),
      .pop   (w_txPop),
      .din   (bus.txPacket),
      .dout  (w_txHead),
      .full  (w_txFull),
      .empty (w_txEmpty)
   );

   // Injection FSM: request a queued packet, hold it stable until granted,
   // back off while the router buffer is full. Grants seen in IDLE are
   // ignored, and IDLE always lasts one cycle so requests are separated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_reqDnStr  <= 1'b0;
         r_packetOut <= '0;
         r_txCount   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_txEmpty && !bus.dnStrFull) begin
                  r_state     <= REQ;
                  r_reqDnStr  <= 1'b1;
                  r_packetOut <= w_txHead;
               end
            end
            REQ: begin
               if (bus.gntDnStr) begin
                  r_state    <= IDLE;
                  r_reqDnStr <= 1'b0;
                  r_txCount  <= r_txCount + 16'd1;
               end else if (bus.dnStrFull) begin
                  // Withdraw; the packet stays at the FIFO head.
                  r_state    <= IDLE;
                  r_reqDnStr <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_reqDnStr <= 1'b0;
            end
         endcase
      end
   end

   assign bus.txReady   = !w_txFull;
   assign bus.reqDnStr  = r_reqDnStr;
   assign bus.packetOut = r_packetOut;
   assign bus.txCount   = r_txCount;

   // ------------------------------------------------------------------
   // RX path: router local output port -> RX FIFO -> core
   // ------------------------------------------------------------------
   logic                 r_gntUpStr;
   logic [15:0]          r_rxCount;

   logic                 w_rxFull;
   logic                 w_rxEmpty;
   logic                 w_rxPop;

   assign w_rxPop = !w_rxEmpty && bus.rxReady;

   // The packet is captured on the edge that ends the grant cycle.
   sync_fifo #(
      .dataWidth    (dataWidth),
      .addressWidth (addressWidth)
   ) u_rxFifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r_gntUpStr),
      .pop   (w_rxPop),
      .din   (bus.packetIn),
      .dout  (bus.rxPacket),
      .full  (w_rxFull),
      .empty (w_rxEmpty)
   );

   // Single-cycle grants: a new grant is only issued when no grant is in
   // flight, so the pending capture has already landed and "not full"
   // guarantees room for the packet about to be granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gntUpStr <= 1'b0;
         r_rxCount  <= '0;
      end else begin
         r_gntUpStr <= bus.reqUpStr && !r_gntUpStr && !w_rxFull;
         if (r_gntUpStr) begin
            r_rxCount <= r_rxCount + 16'd1;
         end
      end
   end

   assign bus.gntUpStr  = r_gntUpStr;
   assign bus.upStrFull = w_rxFull;
   assign bus.rxValid   = !w_rxEmpty;
   assign bus.rxCount   = r_rxCount;

endmodule : local_net_iface
`default_nettype wire

// File: doc/local_net_iface.md
LOCAL_NET_IFACE -- requirements
Module: local_net_iface

Interface
REQ-001 Param dataWidth, default 32, packet/flit width in bits.
REQ-002 Param addressWidth, default 2, FIFO pointer width; each FIFO depth = 2**addressWidth (4).
REQ-003 Param routerNo, default 0, ID of the attached router; informational only.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 txValid  in  1  core offers txPacket.
REQ-007 txPacket  in  dataWidth  core packet to inject.
REQ-008 txReady  out  1  TX FIFO can accept; a push occurs on txValid && txReady.
REQ-009 reqDnStr  out  1  request to the router local input port.
REQ-010 gntDnStr  in  1  one-cycle grant from the router local input port.
REQ-011 dnStrFull  in  1  router local input buffer full.
REQ-012 packetOut  out  dataWidth  packet presented to the router; registered.
REQ-013 reqUpStr  in  1  request from the router local output port.
REQ-014 gntUpStr  out  1  one-cycle grant to the router local output port; registered.
REQ-015 upStrFull  out  1  RX FIFO full.
REQ-016 packetIn  in  dataWidth  packet from the router local output port.
REQ-017 rxValid  out  1  RX FIFO non-empty; rxPacket valid.
REQ-018 rxReady  in  1  core accepts; a pop occurs on rxValid && rxReady.
REQ-019 rxPacket  out  dataWidth  RX FIFO head, combinational from the FIFO.
REQ-020 txCount, rxCount  out  16 each  packets delivered to the router / accepted from the router.

Function
REQ-021 txReady shall equal !txFull and use the pre-pop state; simultaneous push and pop when full is not accepted.
REQ-022 The TX FSM shall have states IDLE and REQ.
REQ-023 TX FSM transitions:
- IDLE->REQ when the TX FIFO is non-empty && !dnStrFull.
- On that edge, packetOut shall load the FIFO head.
REQ-024 In REQ, reqDnStr=1 and packetOut shall remain stable until grant.
REQ-025 In REQ with gntDnStr=1:
- pop the TX FIFO, increment txCount, return to IDLE.
- reqDnStr shall be 0 for at least one cycle between packets.
REQ-026 In REQ with gntDnStr=0 and dnStrFull=1, the FSM shall withdraw to IDLE without popping.
REQ-027 gntDnStr seen in IDLE shall be ignored.
REQ-028 gntUpStr shall assert for exactly one cycle, the cycle after reqUpStr=1 is sampled, when:
- gntUpStr was 0 in the sampling cycle, and
- the RX FIFO has space, counting the pending capture.
REQ-029 packetIn shall be written to the RX FIFO on the edge ending the cycle in which gntUpStr=1; rxCount shall increment on that edge.
REQ-030 upStrFull shall equal rxFull; no gntUpStr shall be issued while full.
REQ-031 A simultaneous RX push and pop shall leave the occupancy unchanged, and shall be allowed when full only if rxReady is sampled with the push.
REQ-032 txCount and rxCount shall wrap 16'hFFFF->0.
REQ-033 FIFO pointers shall wrap modulo depth; full/empty shall be distinguished by an occupancy counter of addressWidth+1 bits.

Reset
REQ-034 While rst=0, the following shall hold:
- FSM=IDLE; FIFOs empty.
- reqDnStr=0, gntUpStr=0, packetOut=0.
- txReady=1, upStrFull=0, rxValid=0.
- txCount=0, rxCount=0.
REQ-035 Reset mid-transfer shall discard all buffered packets without emitting a grant or request on the first cycle after release.

Structure
REQ-036 The FSM state enum (IDLE, REQ) and the default widths shall live in a shared package noc_pkg.
REQ-037 Both FIFOs shall be instances of one sub-module, sync_fifo (params dataWidth, addressWidth; ports push, pop, din, dout, full, empty).

Verification
REQ-038 Push 0xA5A5_0001 with dnStrFull=0 and gntDnStr pulsed on the 2nd REQ cycle:
- reqDnStr rises 1 cycle after push, packetOut=0xA5A5_0001 stable.
- req drops after grant; txCount=1.
REQ-039 Push 5 packets back-to-back with no grant:
- txReady drops after the 4th push; the 5th is held.
- grant one packet -> txReady returns 1 the next cycle.
REQ-040 Set dnStrFull=1 while in REQ with no grant:
- FSM returns to IDLE, FIFO occupancy unchanged.
- dnStrFull=0 -> re-request of the same packet.
REQ-041 Hold reqUpStr=1 with packets 0x1..0x4 and rxReady=0:
- four single-cycle gntUpStr pulses, separated by at least one cycle.
- then upStrFull=1 and no further grants; rxCount=4.
- set rxReady=1 -> rxPacket order 0x1,0x2,0x3,0x4.
REQ-042 Preload txCount=16'hFFFF via 65535 transfers (or force), then one more grant -> txCount=0.
REQ-043 Assert rst=0 asynchronously mid-REQ with 3 packets queued:
- outputs reach reset values immediately.
- after release, no request is made until a new push.
